// File: rtl/apb_regfile_slave_if.sv
// APB bus bundle between an APB master (driver/monitor) and apb_regfile_slave.
// Optional PSLVERR wire is present only when APB_SLVERR_EN is defined.
interface apb_regfile_slave_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
`ifdef APB_SLVERR_EN
   logic        PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PSLVERR
   );
   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PSLVERR
   );
`else
   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA
   );
   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA
   );
`endif
endinterface

// File: rtl/apb_regfile_slave.sv
// APB register-file slave, zero wait states.
// Map: RW scratch regs at 0..NUM_REGS-3, CNT {rd_cnt, wr_cnt} at NUM_REGS-2, ID at NUM_REGS-1.
// Sticky proto_err flags any SETUP/ACCESS sequencing violation.
// Optional feature macro: APB_SLVERR_EN adds combinational PSLVERR on the interface.
module apb_regfile_slave #(
   parameter int unsigned NUM_REGS = 16,
   parameter logic [31:0] ID_VALUE = 32'hA9B0_0001
) (
   input  logic                 PCLK,
   input  logic                 PRESET,
   apb_regfile_slave_if.slave   bus,
   output logic [31:0]          ctrl_out,
   output logic                 proto_err
);

   localparam int unsigned NumRw  = NUM_REGS - 2;
   localparam logic [3:0]  CntIdx = 4'(NUM_REGS - 2);
   localparam logic [3:0]  IdIdx  = 4'(NUM_REGS - 1);

   typedef enum logic {StIdle, StAccess} state_e;

   state_e      state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   logic        write_q, write_d;
   logic [31:0] prdata_q, prdata_d;
   logic        proto_err_q, proto_err_d;
   logic [15:0] wr_cnt_q, wr_cnt_d;
   logic [15:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] rw_q [NumRw];
   logic        commit;
   logic [31:0] rd_mux;

   function automatic logic addr_ok(input logic [7:0] a);
      return (a[1:0] == 2'b00) && (a[7:6] == 2'b00) && (32'(a[5:2]) < NUM_REGS);
   endfunction

   function automatic logic addr_rw(input logic [7:0] a);
      return addr_ok(a) && (32'(a[5:2]) < NumRw);
   endfunction

   // Read-data mux over the live bus address, sampled on the SETUP edge
   always_comb begin
      rd_mux = '0;
      if (addr_ok(bus.PADDR)) begin
         if (bus.PADDR[5:2] == IdIdx) begin
            rd_mux = ID_VALUE;
         end else if (bus.PADDR[5:2] == CntIdx) begin
            rd_mux = {rd_cnt_q, wr_cnt_q};
         end else begin
            for (int unsigned i = 0; i < NumRw; i++) begin
               if (32'(bus.PADDR[5:2]) == i) rd_mux = rw_q[i];
            end
         end
      end
   end

   // Next-state logic: SETUP/ACCESS sequencing, counters and error tracking
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      write_d     = write_q;
      prdata_d    = prdata_q;
      proto_err_d = proto_err_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      commit      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.PSEL && !bus.PENABLE) begin
               state_d = StAccess;
               addr_d  = bus.PADDR;
               write_d = bus.PWRITE;
               if (!bus.PWRITE) prdata_d = rd_mux;
            end else if (bus.PSEL && bus.PENABLE) begin
               proto_err_d = 1'b1;
            end
         end
         StAccess: begin
            if (bus.PSEL && bus.PENABLE && (bus.PADDR == addr_q) && (bus.PWRITE == write_q)) begin
               state_d = StIdle;
               if (write_q) begin
                  // RO and out-of-range writes complete but leave no trace
                  if (addr_rw(addr_q)) begin
                     commit   = 1'b1;
                     wr_cnt_d = wr_cnt_q + 16'd1;
                  end
               end else begin
                  rd_cnt_d = rd_cnt_q + 16'd1;
               end
            end else begin
               proto_err_d = 1'b1;
               if (bus.PSEL && !bus.PENABLE) begin
                  // Treat as a fresh SETUP replacing the dropped transfer
                  state_d = StAccess;
                  addr_d  = bus.PADDR;
                  write_d = bus.PWRITE;
                  if (!bus.PWRITE) prdata_d = rd_mux;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control and status registers
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         write_q     <= 1'b0;
         prdata_q    <= '0;
         proto_err_q <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         write_q     <= write_d;
         prdata_q    <= prdata_d;
         proto_err_q <= proto_err_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
      end
   end

   // RW scratch registers; commit only on a clean ACCESS completion
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         for (int unsigned i = 0; i < NumRw; i++) rw_q[i] <= '0;
      end else if (commit) begin
         for (int unsigned i = 0; i < NumRw; i++) begin
            if (32'(addr_q[5:2]) == i) rw_q[i] <= bus.PWDATA;
         end
      end
   end

   assign bus.PRDATA = prdata_q;
   assign ctrl_out   = rw_q[0];
   assign proto_err  = proto_err_q;

`ifdef APB_SLVERR_EN
   assign bus.PSLVERR = !PRESET && (state_q == StAccess) && bus.PSEL && bus.PENABLE &&
                        (!addr_ok(addr_q) || (write_q && !addr_rw(addr_q)));
`endif

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: reset, R/W, back-to-back, protocol errors,
// RO/out-of-range accesses and reset during a transfer.
module tb_apb_regfile_slave;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] ctrl_out;
   logic proto_err;
   int errors = 0;
   int checks = 0;

   apb_regfile_slave_if bus ();

   apb_regfile_slave #(
      .NUM_REGS (16),
      .ID_VALUE (32'hA9B0_0001)
   ) dut (
      .PCLK      (clk),
      .PRESET    (rst),
      .bus       (bus),
      .ctrl_out  (ctrl_out),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   task automatic bus_idle();
      @(negedge clk);
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b1;
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // SETUP then ACCESS; err is PSLVERR sampled in the ACCESS cycle (0 when absent)
   task automatic apb_write(input logic [7:0] addr, input logic [31:0] data, output logic err);
      @(negedge clk);
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = 1'b1;
      bus.PADDR   = addr;
      bus.PWDATA  = data;
      @(negedge clk);
      bus.PENABLE = 1'b1;
      #1;
`ifdef APB_SLVERR_EN
      err = bus.PSLVERR;
`else
      err = 1'b0;
`endif
   endtask

   task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
      @(negedge clk);
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = 1'b0;
      bus.PADDR   = addr;
      @(negedge clk);
      bus.PENABLE = 1'b1;
      #1;
      data = bus.PRDATA;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      do_reset();
      checks++;
      if (bus.PRDATA !== 32'h0) begin
         errors++; $display("FAIL reset_prdata got=%h exp=%h", bus.PRDATA, 32'h0);
      end
      checks++;
      if (ctrl_out !== 32'h0) begin
         errors++; $display("FAIL reset_ctrl_out got=%h exp=%h", ctrl_out, 32'h0);
      end
      checks++;
      if (proto_err !== 1'b0) begin
         errors++; $display("FAIL reset_proto_err got=%b exp=0", proto_err);
      end
      apb_read(8'h38, d);
      checks++;
      if (d !== 32'h0000_0000) begin
         errors++; $display("FAIL reset_cnt got=%h exp=%h", d, 32'h0);
      end
      apb_read(8'h3C, d);
      checks++;
      if (d !== 32'hA9B0_0001) begin
         errors++; $display("FAIL reset_id got=%h exp=%h", d, 32'hA9B0_0001);
      end
      for (int i = 0; i < 14; i++) begin
         apb_read(8'(i * 4), d);
         checks++;
         if (d !== 32'h0) begin
            errors++; $display("FAIL reset_rw[%0d] got=%h exp=%h", i, d, 32'h0);
         end
      end
      bus_idle();
      checks++;
      if (proto_err !== 1'b0) begin
         errors++; $display("FAIL reset_reads_proto_err got=%b exp=0", proto_err);
      end
   endtask

   task automatic test_write_read();
      logic [31:0] d;
      logic e;
      do_reset();
      apb_write(8'h00, 32'hDEAD_BEEF, e);
      checks++;
      if (e !== 1'b0) begin
         errors++; $display("FAIL wr0_slverr got=%b exp=0", e);
      end
      bus_idle();
      checks++;
      if (ctrl_out !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL wr0_ctrl_out got=%h exp=%h", ctrl_out, 32'hDEAD_BEEF);
      end
      apb_read(8'h38, d);
      checks++;
      if (d !== 32'h0000_0001) begin
         errors++; $display("FAIL wr0_cnt got=%h exp=%h", d, 32'h0000_0001);
      end
      apb_read(8'h00, d);
      checks++;
      if (d !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL rd0_data got=%h exp=%h", d, 32'hDEAD_BEEF);
      end
      bus_idle();
      bus_idle();
      checks++;
      if (bus.PRDATA !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL prdata_hold got=%h exp=%h", bus.PRDATA, 32'hDEAD_BEEF);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d0, d1, d;
      logic e;
      time t0;
      do_reset();
      t0 = $time;
      apb_write(8'h04, 32'h1111_1111, e);
      apb_write(8'h08, 32'h2222_2222, e);
      apb_write(8'h0C, 32'h3333_3333, e);
      apb_read(8'h04, d0);
      apb_read(8'h08, d1);
      // Five 2-cycle transfers: last ACCESS sample lands at 10 + 9*10 + 1
      checks++;
      if (($time - t0) !== 64'd101) begin
         errors++; $display("FAIL b2b_timing got=%0d exp=101", $time - t0);
      end
      checks++;
      if (d0 !== 32'h1111_1111) begin
         errors++; $display("FAIL b2b_rd04 got=%h exp=%h", d0, 32'h1111_1111);
      end
      checks++;
      if (d1 !== 32'h2222_2222) begin
         errors++; $display("FAIL b2b_rd08 got=%h exp=%h", d1, 32'h2222_2222);
      end
      bus_idle();
      apb_read(8'h0C, d);
      checks++;
      if (d !== 32'h3333_3333) begin
         errors++; $display("FAIL b2b_rd0c got=%h exp=%h", d, 32'h3333_3333);
      end
      apb_read(8'h38, d);
      checks++;
      if (d !== 32'h0003_0003) begin
         errors++; $display("FAIL b2b_cnt got=%h exp=%h", d, 32'h0003_0003);
      end
      bus_idle();
   endtask

   task automatic test_proto_err();
      logic [31:0] d;
      // ACCESS without SETUP
      do_reset();
      @(negedge clk);
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b1;
      bus.PWRITE  = 1'b1;
      bus.PADDR   = 8'h08;
      bus.PWDATA  = 32'hFFFF_FFFF;
      bus_idle();
      checks++;
      if (proto_err !== 1'b1) begin
         errors++; $display("FAIL noset_proto_err got=%b exp=1", proto_err);
      end
      apb_read(8'h08, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL noset_reg08 got=%h exp=%h", d, 32'h0);
      end
      apb_read(8'h38, d);
      checks++;
      if (d !== 32'h0001_0000) begin
         errors++; $display("FAIL noset_cnt got=%h exp=%h", d, 32'h0001_0000);
      end
      bus_idle();
      checks++;
      if (proto_err !== 1'b1) begin
         errors++; $display("FAIL sticky_proto_err got=%b exp=1", proto_err);
      end
      // Address changes between SETUP and ACCESS
      do_reset();
      checks++;
      if (proto_err !== 1'b0) begin
         errors++; $display("FAIL proto_err_cleared got=%b exp=0", proto_err);
      end
      @(negedge clk);
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = 1'b1;
      bus.PADDR   = 8'h08;
      bus.PWDATA  = 32'h1234_5678;
      @(negedge clk);
      bus.PENABLE = 1'b1;
      bus.PADDR   = 8'h0C;
      bus_idle();
      checks++;
      if (proto_err !== 1'b1) begin
         errors++; $display("FAIL addrchg_proto_err got=%b exp=1", proto_err);
      end
      apb_read(8'h08, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL addrchg_reg08 got=%h exp=%h", d, 32'h0);
      end
      apb_read(8'h0C, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL addrchg_reg0c got=%h exp=%h", d, 32'h0);
      end
      apb_read(8'h38, d);
      checks++;
      if (d !== 32'h0002_0000) begin
         errors++; $display("FAIL addrchg_cnt got=%h exp=%h", d, 32'h0002_0000);
      end
      bus_idle();
   endtask

   task automatic test_ro_oor();
      logic [31:0] d;
      logic e_id, e_oor, e_cnt;
      do_reset();
      apb_write(8'h3C, 32'h1234_5678, e_id);
      apb_write(8'h41, 32'hFFFF_FFFF, e_oor);
      apb_write(8'h38, 32'hFFFF_FFFF, e_cnt);
`ifdef APB_SLVERR_EN
      checks++;
      if (e_id !== 1'b1) begin
         errors++; $display("FAIL slverr_id got=%b exp=1", e_id);
      end
      checks++;
      if (e_oor !== 1'b1) begin
         errors++; $display("FAIL slverr_oor got=%b exp=1", e_oor);
      end
      checks++;
      if (e_cnt !== 1'b1) begin
         errors++; $display("FAIL slverr_cnt got=%b exp=1", e_cnt);
      end
`endif
      apb_read(8'h3C, d);
      checks++;
      if (d !== 32'hA9B0_0001) begin
         errors++; $display("FAIL ro_id got=%h exp=%h", d, 32'hA9B0_0001);
      end
      apb_read(8'h40, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL oor_rd40 got=%h exp=%h", d, 32'h0);
      end
      apb_read(8'h00, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL oor_no_alias got=%h exp=%h", d, 32'h0);
      end
      apb_read(8'h38, d);
      checks++;
      if (d !== 32'h0003_0000) begin
         errors++; $display("FAIL ro_cnt got=%h exp=%h", d, 32'h0003_0000);
      end
      bus_idle();
      checks++;
      if (proto_err !== 1'b0) begin
         errors++; $display("FAIL ro_proto_err got=%b exp=0", proto_err);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      do_reset();
      @(negedge clk);
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = 1'b1;
      bus.PADDR   = 8'h10;
      bus.PWDATA  = 32'hCAFE_F00D;
      @(negedge clk);
      bus.PENABLE = 1'b1;
      rst         = 1'b1;
      @(negedge clk);
      rst         = 1'b0;
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
      checks++;
      if (proto_err !== 1'b0) begin
         errors++; $display("FAIL rstmid_proto_err got=%b exp=0", proto_err);
      end
      apb_read(8'h38, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL rstmid_cnt got=%h exp=%h", d, 32'h0);
      end
      apb_read(8'h10, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL rstmid_reg10 got=%h exp=%h", d, 32'h0);
      end
      bus_idle();
      // A clean SETUP right after reset only passes cleanly if the FSM restarted in IDLE
      checks++;
      if (proto_err !== 1'b0) begin
         errors++; $display("FAIL rstmid_fsm_idle got=%b exp=0", proto_err);
      end
   endtask

   initial begin
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = 1'b0;
      bus.PADDR   = '0;
      bus.PWDATA  = '0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_proto_err();
      test_ro_oor();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
